// File: rtl/fir_output_requantizer.sv
// -----------------------------------------------------------------------------
// fir_output_requantizer
//
// Output stage of the FIR lowpass filter. Each wide unsigned filter result is
// rounded (add half an LSB of the output scale), right-shifted, saturated to
// an 8-bit sample and pushed into a small first-word-fall-through FIFO that
// feeds the downstream consumer over a valid/ready handshake.
//
// Pipeline: stage 1 (round-add) -> stage 2 (shift + saturate) -> FIFO write,
// so a sample strobed into an empty block shows on out_valid 3 edges later.
//
// Ports:
//   clock       in   rising-edge system clock
//   reset       in   synchronous, active-high reset
//   Data_in     in   [word_size_in-1:0] filter result, sampled when in_valid=1
//   in_valid    in   one-cycle strobe per filter sample
//   Data_out    out  [word_size_out-1:0] FIFO head (holds last value when empty)
//   out_valid   out  FIFO non-empty
//   out_ready   in   consumer takes Data_out this cycle
//   fifo_count  out  [$clog2(fifo_depth):0] occupied FIFO entries
//   overflow    out  sticky: a sample was dropped because the FIFO was full
//   sat_count   out  [7:0] saturated-sample counter, sticks at 255
//                    (present only when FIR_OUT_SAT_CNT_EN is defined)
//
// Build option: define FIR_OUT_SAT_CNT_EN to add the sat_count port/counter.
// -----------------------------------------------------------------------------
module fir_output_requantizer #(
    parameter int word_size_in  = 18,
    parameter int word_size_out = 8,
    parameter int shift         = 10,
    parameter int fifo_depth    = 4
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [word_size_in-1:0]         Data_in,
    input  logic                            in_valid,
    output logic [word_size_out-1:0]        Data_out,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [$clog2(fifo_depth):0]     fifo_count,
    output logic                            overflow
`ifdef FIR_OUT_SAT_CNT_EN
    ,
    output logic [7:0]                      sat_count
`endif
);

    localparam int AW = $clog2(fifo_depth);
    localparam int CW = AW + 1;
    localparam int SW = word_size_in + 1;

    // Half an output LSB; the inner ternary keeps the shift amount legal when shift=0.
    localparam logic [SW-1:0] ROUND_C = (shift > 0) ? (SW'(1) << ((shift > 0) ? (shift - 1) : 0)) : '0;
    localparam logic [SW-1:0] MAX_C   = SW'((1 << word_size_out) - 1);
    localparam logic [CW-1:0] FULL_C  = CW'(fifo_depth);

    // True when the shifted sum no longer fits in the output word.
    function automatic logic sat_hit_f(input logic [SW-1:0] s);
        logic [SW-1:0] q;
        q = s >> shift;
        return (q > MAX_C);
    endfunction

    // Shift and clamp a rounded sum to the output width.
    function automatic logic [word_size_out-1:0] requant_f(input logic [SW-1:0] s);
        logic [SW-1:0] q;
        q = s >> shift;
        if (sat_hit_f(s)) begin
            return '1;
        end else begin
            return q[word_size_out-1:0];
        end
    endfunction

    logic [SW-1:0]            sum_r;
    logic                     s1_valid_r;
    logic [word_size_out-1:0] s2_data_r;
    logic                     s2_valid_r;

    logic [word_size_out-1:0] mem_r [fifo_depth];
    logic [AW-1:0]            wr_ptr_r;
    logic [AW-1:0]            rd_ptr_r;
    logic [CW-1:0]            count_r;
    logic [word_size_out-1:0] data_out_r;
    logic                     out_valid_r;
    logic                     overflow_r;

    logic                     full_s;
    logic                     rd_en_s;
    logic                     wr_en_s;
    logic                     drop_s;
    logic [CW-1:0]            count_next_s;
    logic [AW-1:0]            rd_ptr_next_s;
    logic [word_size_out-1:0] head_next_s;

    // Two-stage requantization pipeline: round-add, then shift/saturate.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s2_valid_r <= 1'b0;
            sum_r      <= '0;
            s2_data_r  <= '0;
        end else begin
            s1_valid_r <= in_valid;
            s2_valid_r <= s1_valid_r;
            if (in_valid) begin
                sum_r <= {1'b0, Data_in} + ROUND_C;
            end else begin
                sum_r <= sum_r;
            end
            if (s1_valid_r) begin
                s2_data_r <= requant_f(sum_r);
            end else begin
                s2_data_r <= s2_data_r;
            end
        end
    end

    // FIFO handshake decode and next-state head/occupancy.
    always_comb begin
        full_s        = (count_r == FULL_C);
        rd_en_s       = out_valid_r && out_ready;
        // A full FIFO still accepts a write when a read frees a slot on the same edge.
        wr_en_s       = s2_valid_r && (!full_s || rd_en_s);
        drop_s        = s2_valid_r && full_s && !rd_en_s;
        rd_ptr_next_s = rd_en_s ? (rd_ptr_r + AW'(1)) : rd_ptr_r;
        case ({wr_en_s, rd_en_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase
        // The new head is the incoming word when it lands in the slot being exposed.
        if (wr_en_s && (wr_ptr_r == rd_ptr_next_s)) begin
            head_next_s = s2_data_r;
        end else begin
            head_next_s = mem_r[rd_ptr_next_s];
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clock) begin
        if (wr_en_s && !reset) begin
            mem_r[wr_ptr_r] <= s2_data_r;
        end
    end

    // FIFO pointers, occupancy, registered head/valid and the sticky overflow flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            count_r     <= '0;
            data_out_r  <= '0;
            out_valid_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            wr_ptr_r    <= wr_en_s ? (wr_ptr_r + AW'(1)) : wr_ptr_r;
            rd_ptr_r    <= rd_ptr_next_s;
            count_r     <= count_next_s;
            out_valid_r <= (count_next_s != '0);
            if (count_next_s != '0) begin
                data_out_r <= head_next_s;
            end else begin
                data_out_r <= data_out_r;
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

`ifdef FIR_OUT_SAT_CNT_EN
    logic [7:0] sat_cnt_r;

    // Count every stage-2 sample that clamps, even if the FIFO later drops it.
    always_ff @(posedge clock) begin
        if (reset) begin
            sat_cnt_r <= 8'd0;
        end else if (s1_valid_r && sat_hit_f(sum_r) && (sat_cnt_r != 8'hFF)) begin
            sat_cnt_r <= sat_cnt_r + 8'd1;
        end else begin
            sat_cnt_r <= sat_cnt_r;
        end
    end

    assign sat_count = sat_cnt_r;
`endif

    assign Data_out   = data_out_r;
    assign out_valid  = out_valid_r;
    assign fifo_count = count_r;
    assign overflow   = overflow_r;

endmodule

// File: doc/fir_output_requantizer.md
Name: fir_output_requantizer

Overview:
- Sits on the output side of the FIR lowpass filter and consumes its wide result (2*8+2 = 18 bits, unsigned) once per sample strobe.
- Rounds and right-shifts each result, saturates it back to an 8-bit sample, and buffers it in a small first-word-fall-through (FWFT) FIFO.
- Presents samples to the downstream consumer over a valid/ready handshake.
- This is the receiving end of the filter's Data_out interface, mirroring the 8-bit sample source that feeds the filter.

Parameters:
- word_size_in, 18, width of the filter result on Data_in (unsigned).
- word_size_out, 8, width of the requantized sample on Data_out.
- shift, 10, right-shift amount; legal range 0..word_size_in-1.
- fifo_depth, 4, FIFO entries; power of two, minimum 2.

Ports:
- clock  input  1  system clock; all logic is rising-edge.
- reset  input  1  synchronous, active-high reset.
- Data_in  input  word_size_in  filter result, sampled only when in_valid=1.
- in_valid  input  1  one-cycle strobe per filter sample.
- Data_out  output  word_size_out  FIFO head sample.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts Data_out this cycle.
- fifo_count  output  log2(fifo_depth)+1  number of occupied FIFO entries.
- overflow  output  1  sticky flag; a sample was dropped because the FIFO was full.

Behaviour:
- Reset (synchronous, active-high) gives: Data_out=0, out_valid=0, fifo_count=0, overflow=0.
  - Both pipeline valid bits are cleared and the FIFO pointers are cleared.
  - Reset asserted mid-operation discards all in-flight and buffered samples on that edge.
- Stage 1, on in_valid=1: register sum = Data_in + (shift>0 ? 2^(shift-1) : 0).
  - sum is word_size_in+1 bits wide, so no carry is lost.
  - The stage-1 valid bit follows in_valid.
- Stage 2: q = sum >> shift.
  - If q > 2^word_size_out-1, the result is all ones (saturation); otherwise it is q[word_size_out-1:0].
  - The result is registered with the stage-2 valid bit.
- Stage 2 valid is the FIFO write request.
  - Latency from the in_valid edge to out_valid (FIFO previously empty) is 3 rising edges: stage 1, stage 2, FIFO write.
- Back-to-back in_valid on consecutive cycles is supported at full throughput.
- FIFO read fires when out_valid=1 and out_ready=1.
  - Data_out always shows the head entry (FWFT).
  - When the FIFO is empty, Data_out holds its last value and out_valid=0.
- Write when not full: the sample is stored.
- Write when full with no read in the same cycle:
  - The sample is dropped and overflow is set.
  - overflow stays set until reset.
  - FIFO contents are unchanged.
- Write when full with a read in the same cycle: both happen; fifo_count is unchanged.
- Read when empty is ignored; out_ready is don't-care while out_valid=0.
- Write into an empty FIFO with out_ready=1 in the same cycle:
  - The sample is written and becomes visible next cycle.
  - There is no combinational bypass.
- Pointers are log2(fifo_depth) bits and wrap modulo fifo_depth.
- fifo_count = writes - reads, in the range 0..fifo_depth.

Optional Feature:
- Macro: FIR_OUT_SAT_CNT_EN.
- When defined:
  - Adds output port sat_count, 8 bits.
  - sat_count increments on every stage-2 sample that saturated, including samples later dropped by the FIFO.
  - It sticks at 255 and is cleared by reset (reset value 0).
- When undefined: the port and its counter are absent; all other behaviour is identical.

Test Plan:
- Reset check: hold reset 2 cycles with in_valid=1 and Data_in=51712, then release.
  - Required: Data_out=0, out_valid=0, fifo_count=0, overflow=0 during reset; no sample is queued from the reset cycles.
- Rounding (shift=10, out_ready=1): Data_in = 51200, 51712, 511, 1023 on spaced strobes.
  - Required: Data_out = 50, 51, 0, 1 in order.
  - Each sample appears 3 edges after its strobe.
- Saturation: Data_in=261632, then 262143.
  - Required: Data_out=255 both times.
  - With FIR_OUT_SAT_CNT_EN: sat_count goes 0→1→2.
- Overflow: out_ready=0; 5 consecutive strobes with Data_in = 1024·k, k=1..5.
  - Required: fifo_count reaches 4; overflow=1 after the 5th write.
  - Raising out_ready then drains 1, 2, 3, 4 (k=5 is lost).
- Full with simultaneous read/write: FIFO full, out_ready=1, one strobe with Data_in=10240.
  - Required: fifo_count stays 4; overflow stays 0; 10 emerges after the 3 older samples.
- Mid-stream reset: 3 samples queued plus 1 in the pipeline, then assert reset for 1 cycle.
  - Required: out_valid=0 and fifo_count=0 on the next cycle; no stale sample appears afterwards.
